// File: rtl/hssim_map_feeder_if.sv
// Paired old/new map beat stream feeding the HSSIM transmit side.
// Source drives the master modport, the feeder consumes through the slave modport.
interface hssim_map_feeder_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] old_tdata;
  logic [DATA_WIDTH-1:0] new_tdata;
  logic                  tlast;

  modport master (output tvalid, old_tdata, new_tdata, tlast, input tready);
  modport slave  (input tvalid, old_tdata, new_tdata, tlast, output tready);
endinterface

// File: rtl/hssim_map_feeder.sv
// HSSIM transmit feeder: registers old/avg/new map beats, counts a frame's beats,
// then flushes the HSSIM pipeline with zero beats before returning to idle.
module hssim_map_feeder #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int INPUT_WIDTH     = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int FLUSH_CYCLES    = 8,
  localparam int DATA_WIDTH     = INPUT_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  hssim_map_feeder_if.slave     s_axis,
  input  logic                  hold,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] old_map,
  output logic [DATA_WIDTH-1:0] avg_map,
  output logic [DATA_WIDTH-1:0] new_map,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  err_tlast
);

  localparam int BEATS   = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;
  logic [FLUSH_W-1:0]    flush_cnt_reg, flush_cnt_next;
  logic                  stall_reg, stall_next;
  logic [DATA_WIDTH-1:0] old_map_reg, old_map_next;
  logic [DATA_WIDTH-1:0] avg_map_reg, avg_map_next;
  logic [DATA_WIDTH-1:0] new_map_reg, new_map_next;
  logic                  frame_start_reg, frame_start_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  err_tlast_reg, err_tlast_next;

  logic                  tready;
  logic                  accept;
  logic                  last_beat;
  logic                  flush_step;
  logic                  flush_end;
  logic [DATA_WIDTH-1:0] avg_beat;

  // Rounded average per pixel; the extra sum bit keeps 255+255+1 from wrapping.
  generate
    for (genvar gi = 0; gi < PIXELS_PER_BEAT; gi++) begin : g_avg
      logic [INPUT_WIDTH:0] sum;
      assign sum = {1'b0, s_axis.old_tdata[gi*INPUT_WIDTH +: INPUT_WIDTH]}
                 + {1'b0, s_axis.new_tdata[gi*INPUT_WIDTH +: INPUT_WIDTH]}
                 + {{INPUT_WIDTH{1'b0}}, 1'b1};
      assign avg_beat[gi*INPUT_WIDTH +: INPUT_WIDTH] = sum[INPUT_WIDTH:1];
    end
  endgenerate

  // Ready is gated by reset so the source sees no acceptance while held in reset.
  assign tready        = aresetn && (state_reg == IDLE || state_reg == STREAM) && !hold;
  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid && tready;
  assign last_beat     = (beat_cnt_reg == LAST_BEAT);
  assign flush_step    = (state_reg == FLUSH) && !hold;
  assign flush_end     = flush_step && (flush_cnt_reg == LAST_FLUSH);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = last_beat ? FLUSH : STREAM;
      STREAM:  if (accept && last_beat) state_next = FLUSH;
      FLUSH:   if (flush_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    beat_cnt_next    = beat_cnt_reg;
    flush_cnt_next   = flush_cnt_reg;
    stall_next       = 1'b1;
    old_map_next     = old_map_reg;
    avg_map_next     = avg_map_reg;
    new_map_next     = new_map_reg;
    frame_start_next = 1'b0;
    frame_done_next  = 1'b0;
    err_tlast_next   = 1'b0;
    if (accept) begin
      stall_next       = 1'b0;
      old_map_next     = s_axis.old_tdata;
      avg_map_next     = avg_beat;
      new_map_next     = s_axis.new_tdata;
      frame_start_next = (state_reg == IDLE);
      err_tlast_next   = (s_axis.tlast != last_beat);
      beat_cnt_next    = last_beat ? '0 : beat_cnt_reg + 1'b1;
      flush_cnt_next   = '0;
    end else if (flush_step) begin
      stall_next      = 1'b0;
      old_map_next    = '0;
      avg_map_next    = '0;
      new_map_next    = '0;
      flush_cnt_next  = flush_end ? '0 : flush_cnt_reg + 1'b1;
      frame_done_next = flush_end;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_reg    <= '0;
      flush_cnt_reg   <= '0;
      stall_reg       <= 1'b1;
      old_map_reg     <= '0;
      avg_map_reg     <= '0;
      new_map_reg     <= '0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      err_tlast_reg   <= 1'b0;
    end else begin
      beat_cnt_reg    <= beat_cnt_next;
      flush_cnt_reg   <= flush_cnt_next;
      stall_reg       <= stall_next;
      old_map_reg     <= old_map_next;
      avg_map_reg     <= avg_map_next;
      new_map_reg     <= new_map_next;
      frame_start_reg <= frame_start_next;
      frame_done_reg  <= frame_done_next;
      err_tlast_reg   <= err_tlast_next;
    end
  end

  assign stall       = stall_reg;
  assign old_map     = old_map_reg;
  assign avg_map     = avg_map_reg;
  assign new_map     = new_map_reg;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign err_tlast   = err_tlast_reg;

endmodule
